// File: rtl/mem_gnt_throttler.sv
// Grant throttler between a core's single-port memory interface and an SRAM model.
// Denies requests pseudo-randomly from a 16-bit LFSR, with a cap on consecutive denied cycles.
module mem_gnt_throttler #(
   parameter int unsigned AddrWidth   = 64,
   parameter int unsigned DataWidth   = 64,
   parameter int unsigned StrbWidth   = 8,
   parameter logic [15:0] LfsrSeed    = 16'hACE1,
   parameter logic [4:0]  StallThresh = 5'd4,
   parameter logic [7:0]  MaxStall    = 8'd7
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 core_req_i,
   input  logic [AddrWidth-1:0] core_addr_i,
   input  logic [DataWidth-1:0] core_wdata_i,
   input  logic [StrbWidth-1:0] core_strb_i,
   input  logic                 core_we_i,
   output logic                 core_gnt_o,
   output logic [DataWidth-1:0] core_rdata_o,
   output logic                 sram_req_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   output logic [StrbWidth-1:0] sram_strb_o,
   output logic                 sram_we_o,
   input  logic [DataWidth-1:0] sram_rdata_i,
   output logic [31:0]          grant_cnt_o,
   output logic [31:0]          stall_cnt_o,
   output logic                 proto_err_o
);

   // state | meaning
   // IDLE  | no denied request outstanding; grant decided by the LFSR draw alone
   // STALL | current request already denied; fields captured, run_q = cycles denied so far

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [15:0]          lfsr_q;
   logic [15:0]          lfsr_d;
   logic [7:0]           run_q, run_d;
   logic [AddrWidth-1:0] cap_addr_q;
   logic [DataWidth-1:0] cap_wdata_q;
   logic [StrbWidth-1:0] cap_strb_q;
   logic                 cap_we_q;
   logic                 cap_load;
   logic                 perr_set;
   logic                 lfsr_pass;
   logic                 run_capped;
   logic                 grant_ok;
   logic                 stall_cyc;
   logic                 fields_diff;
   logic [31:0]          grant_cnt_q, stall_cnt_q;
   logic                 proto_err_q;

   assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign lfsr_pass   = ({1'b0, lfsr_q[3:0]} >= StallThresh);
   assign run_capped  = (state_q == STALL) && (run_q == MaxStall);
   assign fields_diff = (core_addr_i  != cap_addr_q)  ||
                        (core_wdata_i != cap_wdata_q) ||
                        (core_strb_i  != cap_strb_q)  ||
                        (core_we_i    != cap_we_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         run_q   <= '0;
         lfsr_q  <= LfsrSeed;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         lfsr_q  <= lfsr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      cap_load = 1'b0;
      perr_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (core_req_i && !grant_ok) begin
               state_d  = STALL;
               run_d    = 8'd1;
               cap_load = 1'b1;
            end
         end
         STALL: begin
            if (!core_req_i) begin
               state_d  = IDLE;
               run_d    = '0;
               perr_set = 1'b1;
            end else begin
               perr_set = fields_diff;
               if (grant_ok) begin
                  state_d = IDLE;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            run_d   = '0;
         end
      endcase
   end

   // Grant is forced low while reset is asserted, even with throttling disabled.
   always_comb begin
      grant_ok   = ~en_i | lfsr_pass | run_capped;
      core_gnt_o = core_req_i & grant_ok & ~rst_i;
      stall_cyc  = core_req_i & ~grant_ok;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cap_addr_q  <= '0;
         cap_wdata_q <= '0;
         cap_strb_q  <= '0;
         cap_we_q    <= 1'b0;
      end else if (cap_load) begin
         cap_addr_q  <= core_addr_i;
         cap_wdata_q <= core_wdata_i;
         cap_strb_q  <= core_strb_i;
         cap_we_q    <= core_we_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         grant_cnt_q <= '0;
         stall_cnt_q <= '0;
         proto_err_q <= 1'b0;
      end else begin
         if (core_gnt_o && (grant_cnt_q != 32'hFFFF_FFFF)) begin
            grant_cnt_q <= grant_cnt_q + 32'd1;
         end
         if (stall_cyc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (perr_set) begin
            proto_err_q <= 1'b1;
         end
      end
   end

   assign core_rdata_o = sram_rdata_i;
   assign sram_req_o   = core_gnt_o;
   assign sram_addr_o  = core_addr_i;
   assign sram_wdata_o = core_wdata_i;
   assign sram_strb_o  = core_strb_i;
   assign sram_we_o    = core_we_i & core_gnt_o;
   assign grant_cnt_o  = grant_cnt_q;
   assign stall_cnt_o  = stall_cnt_q;
   assign proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_mem_gnt_throttler.sv
// Bench for mem_gnt_throttler: three instances (default, never-stall, always-stall with MaxStall=3)
// share one stimulus stream and are checked against a per-instance request-level reference model.
module tb_mem_gnt_throttler;

   logic        clk, rst, en, req, we;
   logic [63:0] addr, wdata, sram_rdata;
   logic [7:0]  strb;

   logic        gnt [3];
   logic        sreq [3];
   logic        swe [3];
   logic        perr [3];
   logic [63:0] rdata_o [3];
   logic [63:0] saddr [3];
   logic [63:0] swdata [3];
   logic [7:0]  sstrb [3];
   logic [31:0] gcnt [3];
   logic [31:0] scnt [3];

   int n_vec = 0;
   int n_err = 0;

   mem_gnt_throttler u_dflt (
      .clk_i(clk), .rst_i(rst), .en_i(en), .core_req_i(req), .core_addr_i(addr),
      .core_wdata_i(wdata), .core_strb_i(strb), .core_we_i(we), .core_gnt_o(gnt[0]),
      .core_rdata_o(rdata_o[0]), .sram_req_o(sreq[0]), .sram_addr_o(saddr[0]),
      .sram_wdata_o(swdata[0]), .sram_strb_o(sstrb[0]), .sram_we_o(swe[0]),
      .sram_rdata_i(sram_rdata), .grant_cnt_o(gcnt[0]), .stall_cnt_o(scnt[0]), .proto_err_o(perr[0]));

   mem_gnt_throttler #(.StallThresh(5'd0)) u_never (
      .clk_i(clk), .rst_i(rst), .en_i(en), .core_req_i(req), .core_addr_i(addr),
      .core_wdata_i(wdata), .core_strb_i(strb), .core_we_i(we), .core_gnt_o(gnt[1]),
      .core_rdata_o(rdata_o[1]), .sram_req_o(sreq[1]), .sram_addr_o(saddr[1]),
      .sram_wdata_o(swdata[1]), .sram_strb_o(sstrb[1]), .sram_we_o(swe[1]),
      .sram_rdata_i(sram_rdata), .grant_cnt_o(gcnt[1]), .stall_cnt_o(scnt[1]), .proto_err_o(perr[1]));

   mem_gnt_throttler #(.StallThresh(5'd16), .MaxStall(8'd3)) u_always (
      .clk_i(clk), .rst_i(rst), .en_i(en), .core_req_i(req), .core_addr_i(addr),
      .core_wdata_i(wdata), .core_strb_i(strb), .core_we_i(we), .core_gnt_o(gnt[2]),
      .core_rdata_o(rdata_o[2]), .sram_req_o(sreq[2]), .sram_addr_o(saddr[2]),
      .sram_wdata_o(swdata[2]), .sram_strb_o(sstrb[2]), .sram_we_o(swe[2]),
      .sram_rdata_i(sram_rdata), .grant_cnt_o(gcnt[2]), .stall_cnt_o(scnt[2]), .proto_err_o(perr[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one record of request-level state per instance.
   int                 thr [3] = '{4, 0, 16};
   int                 mx  [3] = '{7, 7, 3};
   logic [15:0]        m_lfsr [3];
   bit                 m_stalled [3];
   int                 m_denied [3];
   logic [136:0]       m_cap [3];
   longint unsigned    m_gcnt [3];
   longint unsigned    m_scnt [3];
   bit                 m_perr [3];

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic bit m_ok(input int i);
      logic [15:0] v;
      v = m_lfsr[i];
      return !en || (int'(v[3:0]) >= thr[i]) || (m_stalled[i] && m_denied[i] == mx[i]);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 3; i++) begin
         m_lfsr[i] = 16'hACE1; m_stalled[i] = 0; m_denied[i] = 0; m_cap[i] = '0;
         m_gcnt[i] = 0; m_scnt[i] = 0; m_perr[i] = 0;
      end
   endtask

   task automatic m_update(input int i);
      bit ok;
      logic [136:0] f;
      ok = m_ok(i);
      f  = {addr, wdata, strb, we};
      if (req && ok && m_gcnt[i] < 64'hFFFF_FFFF) m_gcnt[i]++;
      if (req && !ok && m_scnt[i] < 64'hFFFF_FFFF) m_scnt[i]++;
      if (m_stalled[i]) begin
         if (!req || f != m_cap[i]) m_perr[i] = 1;
         if (!req || ok) begin
            m_stalled[i] = 0; m_denied[i] = 0;
         end else begin
            m_denied[i]++;
         end
      end else if (req && !ok) begin
         m_stalled[i] = 1; m_denied[i] = 1; m_cap[i] = f;
      end
      m_lfsr[i] = lfsr_next(m_lfsr[i]);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step_comb();
      bit ok;
      #2;
      for (int i = 0; i < 3; i++) begin
         ok = m_ok(i);
         chk($sformatf("gnt[%0d]", i), 64'(gnt[i]), 64'(req & ok));
         chk($sformatf("sram_req[%0d]", i), 64'(sreq[i]), 64'(req & ok));
         chk($sformatf("sram_we[%0d]", i), 64'(swe[i]), 64'(we & req & ok));
         chk($sformatf("sram_addr[%0d]", i), saddr[i], addr);
         chk($sformatf("sram_wdata[%0d]", i), swdata[i], wdata);
         chk($sformatf("sram_strb[%0d]", i), 64'(sstrb[i]), 64'(strb));
         chk($sformatf("rdata[%0d]", i), rdata_o[i], sram_rdata);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      for (int i = 0; i < 3; i++) m_update(i);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("grant_cnt[%0d]", i), 64'(gcnt[i]), m_gcnt[i]);
         chk($sformatf("stall_cnt[%0d]", i), 64'(scnt[i]), m_scnt[i]);
         chk($sformatf("proto_err[%0d]", i), 64'(perr[i]), 64'(m_perr[i]));
      end
   endtask

   task automatic cyc();
      step_comb();
      step_clk();
   endtask

   task automatic hw_reset();
      req = 0;
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      m_reset();
   endtask

   typedef struct {
      logic        req;
      logic        en;
      logic [63:0] addr;
      logic        we;
      logic        gnt;
      int          gcnt;
      int          scnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic e, input logic [63:0] a, input logic w,
                      input logic g, input int gc, input int sc);
      vec_t v;
      v.req = r; v.en = e; v.addr = a; v.we = w; v.gnt = g; v.gcnt = gc; v.scnt = sc;
      tbl.push_back(v);
   endtask

   initial begin
      // Expectations for u_always (StallThresh=16, MaxStall=3): every request waits 3 cycles.
      for (int k = 0; k < 4; k++) begin
         add(1, 1, 64'h8000_0100 + 64'(8 * k), 0, 0, k,     3 * k + 1);
         add(1, 1, 64'h8000_0100 + 64'(8 * k), 0, 0, k,     3 * k + 2);
         add(1, 1, 64'h8000_0100 + 64'(8 * k), 0, 0, k,     3 * k + 3);
         add(1, 1, 64'h8000_0100 + 64'(8 * k), 0, 1, k + 1, 3 * k + 3);
         add(0, 1, 64'h0,                      0, 0, k + 1, 3 * k + 3);
      end
      add(1, 1, 64'h8000_0200, 1, 0, 4, 13);
      add(1, 0, 64'h8000_0200, 1, 1, 5, 13);
      add(1, 1, 64'h8000_0208, 0, 0, 5, 14);
      add(1, 1, 64'h8000_0208, 0, 0, 5, 15);
      add(1, 1, 64'h8000_0208, 0, 0, 5, 16);
      add(1, 1, 64'h8000_0208, 0, 1, 6, 16);
      add(1, 1, 64'h8000_0210, 0, 0, 6, 17);
      add(1, 1, 64'h8000_0210, 0, 0, 6, 18);
      add(1, 1, 64'h8000_0210, 0, 0, 6, 19);
      add(1, 1, 64'h8000_0210, 0, 1, 7, 19);
      add(0, 1, 64'h0,         0, 0, 7, 19);

      rst = 1; req = 1; en = 0; we = 0; addr = '0; wdata = '0; strb = '0; sram_rdata = '0;
      #3;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_gnt[%0d]", i), 64'(gnt[i]), 64'd0);
         chk($sformatf("rst_sreq[%0d]", i), 64'(sreq[i]), 64'd0);
         chk($sformatf("rst_gcnt[%0d]", i), 64'(gcnt[i]), 64'd0);
         chk($sformatf("rst_perr[%0d]", i), 64'(perr[i]), 64'd0);
      end
      @(posedge clk);
      #1;
      rst = 0;
      m_reset();

      // Transparent mode: 10 back-to-back reads.
      en = 0; req = 1; we = 0; strb = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         addr = 64'h8000_0000 + 64'(8 * k);
         cyc();
      end
      req = 0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t1_gcnt[%0d]", i), 64'(gcnt[i]), 64'd10);
         chk($sformatf("t1_scnt[%0d]", i), 64'(scnt[i]), 64'd0);
      end

      // Never-stall instance: grants every request; read data passes through a cycle later.
      hw_reset();
      en = 1;
      for (int k = 0; k < 12; k++) begin
         req = 1; addr = {$urandom, $urandom}; we = $urandom_range(0, 1);
         wdata = {$urandom, $urandom}; strb = 8'($urandom);
         step_comb();
         chk("t2_gnt", 64'(gnt[1]), 64'd1);
         step_clk();
      end
      req = 1; we = 0; addr = 64'h8000_0000;
      step_comb();
      chk("t2_read_gnt", 64'(gnt[1]), 64'd1);
      step_clk();
      req = 0; sram_rdata = 64'h8000_0000;
      step_comb();
      chk("t2_rdata", rdata_o[1], 64'h8000_0000);
      step_clk();

      // Table-driven: MaxStall boundary, en drop during stall, back-to-back requests.
      hw_reset();
      wdata = 64'h1111_2222_3333_4444; strb = 8'h0F;
      foreach (tbl[n]) begin
         req = tbl[n].req; en = tbl[n].en; addr = tbl[n].addr; we = tbl[n].we;
         step_comb();
         chk($sformatf("tbl%0d_gnt", n), 64'(gnt[2]), 64'(tbl[n].gnt));
         step_clk();
         chk($sformatf("tbl%0d_gcnt", n), 64'(gcnt[2]), 64'(tbl[n].gcnt));
         chk($sformatf("tbl%0d_scnt", n), 64'(scnt[2]), 64'(tbl[n].scnt));
      end
      chk("tbl_perr", 64'(perr[2]), 64'd0);

      // Address changes mid-stall on a write.
      hw_reset();
      en = 1; req = 1; we = 1; addr = 64'h8000_0010;
      cyc();
      cyc();
      chk("t4_perr_before", 64'(perr[2]), 64'd0);
      addr = 64'h8000_0018;
      cyc();
      chk("t4_perr_set", 64'(perr[2]), 64'd1);
      cyc();
      req = 0;
      for (int k = 0; k < 3; k++) cyc();
      chk("t4_perr_sticky", 64'(perr[2]), 64'd1);

      // Request dropped mid-stall: no write reaches the SRAM, machine returns to IDLE.
      hw_reset();
      en = 1; req = 1; we = 1; addr = 64'h8000_0020;
      cyc();
      cyc();
      req = 0;
      step_comb();
      chk("t5_no_we", 64'(swe[2]), 64'd0);
      step_clk();
      chk("t5_perr", 64'(perr[2]), 64'd1);
      req = 1; we = 0; addr = 64'h8000_0028;
      for (int k = 0; k < 4; k++) begin
         step_comb();
         chk($sformatf("t5_regnt%0d", k), 64'(gnt[2]), 64'(k == 3));
         step_clk();
      end
      req = 0;

      // Asynchronous reset mid-stall.
      hw_reset();
      en = 1; req = 1; we = 0; addr = 64'h8000_0030;
      cyc();
      cyc();
      #2;
      rst = 1;
      #1;
      chk("t6_gnt", 64'(gnt[2]), 64'd0);
      chk("t6_gcnt", 64'(gcnt[2]), 64'd0);
      chk("t6_scnt", 64'(scnt[2]), 64'd0);
      chk("t6_perr", 64'(perr[2]), 64'd0);
      chk("t6_lfsr", 64'(u_always.lfsr_q), 64'hACE1);
      req = 0;
      #2;
      rst = 0;
      m_reset();
      step_clk();
      chk("t6_lfsr_next", 64'(u_always.lfsr_q), 64'h59C3);

      // Randomized traffic, mostly protocol-legal from the default instance's view.
      hw_reset();
      for (int k = 0; k < 400; k++) begin
         sram_rdata = {$urandom, $urandom};
         if (m_stalled[0] && $urandom_range(0, 39) != 0) begin
            req = 1;
         end else begin
            req   = ($urandom_range(0, 3) != 0);
            en    = ($urandom_range(0, 7) != 0);
            we    = $urandom_range(0, 1);
            addr  = {$urandom, $urandom};
            wdata = {$urandom, $urandom};
            strb  = 8'($urandom);
         end
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
